// File: rtl/note_player.sv
// Note sequencer consumer: requests a note with a next pulse, plays it as a square
// wave for its decoded length, keeps a short silent gap, then requests the following note.
module note_player #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int UNIT_CYCLES   = 5_000_000,
  parameter int GAP_CYCLES    = 250_000,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       stop,
  input  logic [3:0] note_in,
  input  logic [1:0] length_in,
  output logic       next,
  output logic       finish,
  output logic       tone,
  output logic       busy,
  output logic [3:0] cur_note
);

  localparam int HALF_C = CLK_HZ / (2 * 262);
  localparam int HALF_D = CLK_HZ / (2 * 294);
  localparam int HALF_E = CLK_HZ / (2 * 330);
  localparam int HALF_F = CLK_HZ / (2 * 349);
  localparam int HALF_G = CLK_HZ / (2 * 392);
  localparam int HALF_A = CLK_HZ / (2 * 440);
  localparam int HALF_B = CLK_HZ / (2 * 494);
  localparam int HP_W   = $clog2(HALF_C + 1);
  localparam int CNT_W  = $clog2(4 * UNIT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, PLAY, GAP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [HP_W-1:0]   hp_cnt;
  logic [HP_W-1:0]   half;

  // A half-period of zero marks a rest: the tone generator never runs.
  function automatic logic [HP_W-1:0] half_period(input logic [3:0] code);
    logic [HP_W-1:0] h;
    case (code)
      4'b0001:          h = HP_W'(HALF_C);
      4'b0010:          h = HP_W'(HALF_D);
      4'b0100:          h = HP_W'(HALF_E);
      4'b0101:          h = HP_W'(HALF_F);
      4'b0110:          h = HP_W'(HALF_G);
      4'b1000:          h = HP_W'(HALF_A);
      4'b0111, 4'b0011: h = HP_W'(HALF_B);
      default:          h = '0;
    endcase
    return h;
  endfunction

  // Audible part of the note; the gap takes the remainder of the last unit.
  function automatic logic [CNT_W-1:0] play_len(input logic [1:0] len);
    return CNT_W'((int'(len) + 1) * UNIT_CYCLES - GAP_CYCLES - 1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      hp_cnt   <= '0;
      half     <= '0;
      next     <= 1'b0;
      finish   <= 1'b0;
      tone     <= 1'b0;
      busy     <= 1'b0;
      cur_note <= 4'd0;
    end else begin
      next   <= 1'b0;
      finish <= 1'b0;
      if (stop && state != IDLE) begin
        state    <= IDLE;
        cnt      <= '0;
        hp_cnt   <= '0;
        tone     <= 1'b0;
        busy     <= 1'b0;
        finish   <= 1'b1;
        cur_note <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            if (en && !stop) begin
              next  <= 1'b1;
              busy  <= 1'b1;
              cnt   <= CNT_W'(SETTLE_CYCLES - 1);
              state <= SETTLE;
            end
          end
          SETTLE: begin
            tone <= 1'b0;
            if (cnt == '0) begin
              cur_note <= note_in;
              half     <= half_period(note_in);
              hp_cnt   <= half_period(note_in) - 1'b1;
              cnt      <= play_len(length_in);
              state    <= PLAY;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          PLAY: begin
            if (half != '0) begin
              if (hp_cnt == '0) begin
                tone   <= ~tone;
                hp_cnt <= half - 1'b1;
              end else begin
                hp_cnt <= hp_cnt - 1'b1;
              end
            end
            // The last-assigned tone wins, so the gap always starts silent.
            if (cnt == '0) begin
              tone  <= 1'b0;
              cnt   <= CNT_W'(GAP_CYCLES - 1);
              state <= GAP;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          GAP: begin
            tone <= 1'b0;
            if (cnt == '0) begin
              if (en) begin
                next  <= 1'b1;
                cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                state <= SETTLE;
              end else begin
                busy     <= 1'b0;
                cur_note <= 4'd0;
                state    <= IDLE;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
